// File: rtl/mux_pkg.sv
// Shared constants and helpers for the arbitrated M:1 output selector.
package mux_pkg;

  // Arbitration modes
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational M-way arbiter: round-robin starting at ptr, or fixed
// priority with the lowest index winning. Grant is one-hot or zero.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int M        = 4,
  parameter  int PRIORITY = PRIO_RR,
  localparam int SW       = sel_width(M)
) (
  input  logic [M-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [M-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  logic found;
  int   cand;

  // Scan the M candidates in search order and take the first requester
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < M; i++) begin
      if (PRIORITY == PRIO_FIXED) begin
        cand = i;
      end else begin
        cand = int'(ptr) + i;
        if (cand >= M) cand = cand - M;
      end
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = SW'(cand);
      end
    end
  end

endmodule

// File: rtl/mux_arb_mton.sv
// Registered, arbitrated M-input to one-output selector with valid/ready
// handshakes on both sides. Owns the output register and the round-robin
// pointer; arbitration itself lives in rr_arbiter.
module mux_arb_mton
  import mux_pkg::*;
#(
  parameter  int N        = 32,
  parameter  int M        = 4,
  parameter  int PRIORITY = PRIO_RR,
  localparam int SEL_W    = sel_width(M)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [M*N-1:0]     in_data,
  input  logic [M-1:0]       in_valid,
  output logic [M-1:0]       in_ready,
  output logic [N-1:0]       out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [N-1:0]     out_data_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] ptr_reg;
  logic [SEL_W-1:0] ptr_next;

  logic             load_en;
  logic [M-1:0]     req;
  logic [M-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic [N-1:0]     win_data;

  // Register can take a new word when empty or being drained this cycle;
  // requests are masked otherwise (and during reset) so no grant is issued.
  assign load_en  = !out_valid_reg || out_ready;
  assign req      = (load_en && !rst) ? in_valid : '0;
  assign in_ready = grant;

  rr_arbiter #(
    .M        (M),
    .PRIORITY (PRIORITY)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Winner's word; only grant_idx (not in_data) steers the select
  always_comb begin
    win_data = in_data[int'(grant_idx)*N +: N];
  end

  // Pointer moves to the channel after the winner, wrapping at M
  always_comb begin
    if (grant_idx == SEL_W'(M - 1)) ptr_next = '0;
    else                            ptr_next = grant_idx + 1'b1;
  end

  // Output register, pointer and valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else if (load_en) begin
      if (|grant) begin
        out_data_reg  <= win_data;
        out_sel_reg   <= grant_idx;
        out_valid_reg <= 1'b1;
        if (PRIORITY == PRIO_RR) ptr_reg <= ptr_next;
      end else begin
        // Nothing to load: drop valid, keep last data/sel for visibility
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_arb_mton.sv
// Bench for mux_arb_mton: table-driven round-robin vectors with a queue of
// expected output words, plus hand-written reset, backpressure and
// fixed-priority sequences.
module tb_mux_arb_mton;

  localparam int N = 32;
  localparam int M = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic [N-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  logic [M*N-1:0] fp_in_data;
  logic [M-1:0]   fp_in_valid;
  logic [M-1:0]   fp_in_ready;
  logic [N-1:0]   fp_out_data;
  logic [1:0]     fp_out_sel;
  logic           fp_out_valid;
  logic           fp_out_ready;

  always #5 clk = ~clk;

  mux_arb_mton #(.N(N), .M(M), .PRIORITY(0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_arb_mton #(.N(N), .M(M), .PRIORITY(1)) dut_fp (
    .clk(clk), .rst(rst), .in_data(fp_in_data), .in_valid(fp_in_valid),
    .in_ready(fp_in_ready), .out_data(fp_out_data), .out_sel(fp_out_sel),
    .out_valid(fp_out_valid), .out_ready(fp_out_ready)
  );

  typedef struct {
    logic [3:0]     v;
    logic           ordy;
    logic [3:0]     exp_rdy;
    logic           exp_ov;    // out_valid after the edge when nothing loads
    logic [M*N-1:0] data;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_d = '0;
  logic [1:0]  last_s = '0;
  vec_t        tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [M*N-1:0] pattern(input int k);
    logic [M*N-1:0] d;
    for (int i = 0; i < M; i++) d[i*N +: N] = {8'h5A, 8'(k), 8'(i), 8'hC3};
    return d;
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic ordy,
                              input logic [3:0] rdy, input logic ov, input int k);
    vec_t t;
    t.v = v; t.ordy = ordy; t.exp_rdy = rdy; t.exp_ov = ov; t.data = pattern(k);
    return t;
  endfunction

  // One cycle on the round-robin DUT: drive, check grant mid-cycle, queue
  // the expected word, then compare the output register after the edge.
  task automatic step(input vec_t t, input string name);
    exp_t e;
    int   idx;
    in_valid = t.v; out_ready = t.ordy; in_data = t.data;
    @(negedge clk);
    chk({name, " in_ready"}, 32'(in_ready), 32'(t.exp_rdy));
    if (t.exp_rdy != 0) begin
      idx = 0;
      for (int i = 0; i < M; i++) if (t.exp_rdy[i]) idx = i;
      e.d = t.data[idx*N +: N];
      e.s = 2'(idx);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (t.exp_rdy != 0) begin
      e = sb.pop_front();
      chk({name, " out_valid"}, 32'(out_valid), 32'd1);
      chk({name, " out_data"}, out_data, e.d);
      chk({name, " out_sel"}, 32'(out_sel), 32'(e.s));
      last_d = e.d; last_s = e.s;
    end else begin
      chk({name, " out_valid"}, 32'(out_valid), 32'(t.exp_ov));
      chk({name, " out_data hold"}, out_data, last_d);
      chk({name, " out_sel hold"}, 32'(out_sel), 32'(last_s));
    end
    $display("step %-10s v=%b ordy=%b in_ready=%b out_valid=%b out_sel=%0d out_data=%h",
             name, t.v, t.ordy, in_ready, out_valid, out_sel, out_data);
  endtask

  task automatic do_reset(input int cycles, input string name);
    rst = 1'b1;
    in_valid = 4'b1111; out_ready = 1'b1; in_data = pattern(99);
    fp_in_valid = 4'b1111; fp_out_ready = 1'b1; fp_in_data = pattern(98);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk({name, " in_ready"}, 32'(in_ready), 32'd0);
      chk({name, " fp in_ready"}, 32'(fp_in_ready), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    fp_in_valid = '0;
    chk({name, " out_valid"}, 32'(out_valid), 32'd0);
    chk({name, " out_data"}, out_data, 32'd0);
    chk({name, " out_sel"}, 32'(out_sel), 32'd0);
    sb.delete();
    last_d = '0; last_s = '0;
    $display("reset %s cycles=%0d out_valid=%b out_data=%h", name, cycles, out_valid, out_data);
  endtask

  task automatic fp_step(input logic [3:0] v, input logic [3:0] exp_rdy,
                         input logic [1:0] exp_sel, input int k);
    logic [M*N-1:0] d;
    d = pattern(k);
    fp_in_valid = v; fp_out_ready = 1'b1; fp_in_data = d;
    @(negedge clk);
    chk("fp in_ready", 32'(fp_in_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    chk("fp out_valid", 32'(fp_out_valid), 32'd1);
    chk("fp out_sel", 32'(fp_out_sel), 32'(exp_sel));
    chk("fp out_data", fp_out_data, d[int'(exp_sel)*N +: N]);
    $display("fp v=%b in_ready=%b out_sel=%0d out_data=%h", v, fp_in_ready, fp_out_sel, fp_out_data);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t t;
    // Round-robin table, starting from reset (ptr = 0, register empty)
    tbl[0] = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 0);
    tbl[0].data[2*N +: N] = 32'hE59F1020;
    tbl[1] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1);  // load, nothing valid: empty
    tbl[2] = mk(4'b0011, 1'b0, 4'b0001, 1'b1, 2);  // ptr=3 wraps to ch0
    tbl[3] = mk(4'b0011, 1'b0, 4'b0000, 1'b1, 3);  // full, stalled
    tbl[4] = mk(4'b0011, 1'b1, 4'b0010, 1'b1, 4);  // ptr=1
    tbl[5] = mk(4'b1001, 1'b1, 4'b1000, 1'b1, 5);  // ptr=2 -> ch3
    tbl[6] = mk(4'b1001, 1'b1, 4'b0001, 1'b1, 6);  // ptr=0 -> ch0
    tbl[7] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 7);  // full, stalled
    tbl[8] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 8);  // drained

    rst = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0;
    fp_in_valid = '0; fp_out_ready = 1'b0; fp_in_data = '0;
    @(posedge clk); #1;

    do_reset(2, "init");
    for (int k = 0; k < 9; k++) step(tbl[k], $sformatf("tbl%0d", k));

    // Fairness: all valid from reset -> 0,1,2,3,0,1
    do_reset(1, "rr");
    for (int k = 0; k < 6; k++) begin
      logic [3:0] r;
      r = 4'b0001 << (k % 4);
      step(mk(4'b1111, 1'b1, r, 1'b1, 20 + k), $sformatf("rr%0d", k));
    end

    // Backpressure: ptr=2 now, load AA000004 on ch3 then stall 3 cycles
    t = mk(4'b1000, 1'b1, 4'b1000, 1'b1, 30);
    t.data[3*N +: N] = 32'hAA000004;
    step(t, "bp_load");
    for (int k = 0; k < 3; k++) step(mk(4'b1111, 1'b0, 4'b0000, 1'b1, 31 + k), $sformatf("bp_hold%0d", k));
    t = mk(4'b0010, 1'b1, 4'b0010, 1'b1, 34);
    t.data[1*N +: N] = 32'hE1A020A2;
    step(t, "bp_release");

    // Fixed priority instance
    for (int k = 0; k < 3; k++) fp_step(4'b1111, 4'b0001, 2'd0, 40 + k);
    fp_step(4'b1010, 4'b0010, 2'd1, 43);
    fp_step(4'b1000, 4'b1000, 2'd3, 44);
    fp_in_valid = '0;

    // Mid-operation reset: hold a word, then pulse reset
    step(mk(4'b0100, 1'b1, 4'b0100, 1'b1, 50), "mr_load");
    step(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 51), "mr_hold");
    do_reset(1, "mid");
    step(mk(4'b1111, 1'b1, 4'b0001, 1'b1, 52), "mr_first");
    step(mk(4'b1111, 1'b1, 4'b0010, 1'b1, 53), "mr_second");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arb_mton.md
# mux_arb_mton

Registered, arbitrated M-input to one-output datapath selector. It is the sequential successor of the combinational 2:1 N-bit mux. M request channels of N bits each compete for a single output register. A round-robin or fixed-priority arbiter picks the winner, and a valid/ready handshake governs both sides. It sits in the processor wherever several producers share one consumer, such as writeback-source selection and memory-port sharing.

## Interface
Parameters:
- N, 32, data width in bits (≥1)
- M, 4, number of input channels (≥2)
- PRIORITY, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  M*N  channel i occupies bits [i*N +: N]
- in_valid  input  M  channel i presents a word
- in_ready  output  M  channel i word accepted this cycle (one-hot or zero)
- out_data  output  N  registered selected word
- out_sel  output  SEL_W  index of the channel that produced out_data; SEL_W = $clog2(M)
- out_valid  output  1  out_data holds an untaken word
- out_ready  input  1  consumer takes out_data this cycle

## Operation
- Two states of the output register:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- load_en = !out_valid || out_ready. The register may be (re)loaded this cycle.
- Arbitration is combinational over in_valid and runs only when load_en = 1 and rst = 0. Otherwise in_ready = 0.
- Round-robin (PRIORITY = 0): search starts at pointer ptr and wraps modulo M. The first valid channel wins.
- Fixed priority (PRIORITY = 1): the lowest-index valid channel wins, and ptr is unused.
- in_ready[g] = 1 for the winner g only. The transfer on channel g is in_valid[g] && in_ready[g].
- On a transfer:
  - out_data ← channel g word, out_sel ← g, out_valid ← 1.
  - Round-robin only: ptr ← (g+1) mod M.
- On load_en with no valid input: out_valid ← 0. out_data and out_sel keep their last values.
- On !load_en (FULL and out_ready = 0): out_data, out_sel, out_valid and ptr all hold.
- Simultaneous consume and load: the consumer takes the old word and the new word is loaded on the same edge. Throughput is one word per cycle.
- Inputs need not hold once their in_valid drops. A channel that is not granted must keep in_valid asserted to be served.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0. in_ready = 0 while rst = 1.
- Reset mid-operation discards any held word and restarts round-robin at channel 0 on the first cycle after release.
- Latency: a word accepted at edge k is visible on out_data/out_valid after edge k (one cycle).
- in_ready depends combinationally on in_valid, out_valid and out_ready. There is no combinational path from in_data to any output.
- Fairness: with all M channels continuously valid and out_ready = 1, each channel is served exactly once every M cycles.

## Structure
- Package mux_pkg: the function sel_width(M) and the constants PRIO_RR = 0 and PRIO_FIXED = 1.
- Sub-module rr_arbiter: parameters M and PRIORITY; inputs req[M-1:0] and ptr; outputs grant (one-hot) and grant_idx. It is purely combational and reusable.
- The top level owns the output register, ptr and the handshake logic.

## Test plan
Default configuration for all scenarios: N=32, M=4, PRIORITY=0 unless stated.
- Reset: hold rst = 1 for 2 cycles with in_valid = 4'b1111 → in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0.
- Single channel: in_valid = 4'b0100, channel 2 = 32'hE59F1020, out_ready = 1 → in_ready = 4'b0100. Next cycle: out_data = E59F1020, out_sel = 2, out_valid = 1.
- Round-robin: in_valid = 4'b1111 constant, out_ready = 1 → out_sel sequence 0,1,2,3,0,1; each channel granted once per 4 cycles.
- Backpressure: out_data = 32'hAA000004 valid, out_ready = 0 for 3 cycles → in_ready = 0 and out_data stable. Raise out_ready with channel 1 valid (32'hE1A020A2) → same-cycle in_ready[1] = 1, next cycle out_data = E1A020A2.
- Fixed priority (PRIORITY = 1): in_valid = 4'b1111 → out_sel = 0 every cycle. in_valid = 4'b1010 → out_sel = 1.
- Mid-operation reset: with out_valid = 1, out_ready = 0, pulse rst for 1 cycle → out_valid = 0. Then in_valid = 4'b1111 → first out_sel = 0.
